dice_game_ctrl: RTL

Two-player turn controller for the electronic dice. It shares one dice roller between players A and B. It gates the current player's button onto the dice's `button` input and rejects rolls that are too short. After each release it captures the settled throw, accumulates each player's score and declares a winner when a player reaches `TARGET`. It sits between the two board push-buttons and the dice instance, and feeds the score/LED display logic.

---
 rtl/dice_game_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/dice_game_ctrl.sv
// dice_game_ctrl: two-player turn controller sharing one dice roller, with scoring and win detection
// Optional feature macro: DICE_CTRL_BONUS_SIX_EN (a non-winning six grants the same player another roll)
module dice_game_ctrl #(
    parameter int TARGET   = 20,
    parameter int SCORE_W  = 5,
    parameter int MIN_ROLL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_a,
    input  logic               btn_b,
    input  logic               new_game,
    input  logic [2:0]         throw,
    output logic               dice_button,
    output logic               turn,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic [2:0]         last_throw,
    output logic               throw_valid,
    output logic [1:0]         winner,
    output logic               game_over
);
    typedef enum logic [1:0] {WAIT, ROLL, SETTLE, OVER} state_t;
    localparam int CW = $clog2(MIN_ROLL + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MIN_ROLL);
    localparam logic [SCORE_W:0] TGT = (SCORE_W + 1)'(TARGET);
    state_t               state;
    logic [CW-1:0]        hold;
    logic                 btn_cur;
    logic [SCORE_W-1:0]   cur_score;
    logic [SCORE_W:0]     sum;
    logic                 roll_ok;
    logic                 keep_turn;
    // current player's view: button, score, widened sum and roll validity
    always_comb begin
        btn_cur   = turn ? btn_b : btn_a;
        cur_score = turn ? score_b : score_a;
        sum       = {1'b0, cur_score} + {{(SCORE_W - 2){1'b0}}, throw};
        roll_ok   = (hold == HOLD_MAX) && (throw != 3'd0) && (throw != 3'd7);
`ifdef DICE_CTRL_BONUS_SIX_EN
        keep_turn = (throw == 3'd6);
`else
        keep_turn = 1'b0;
`endif
    end
    // turn FSM with registered outputs; new_game acts as a soft reset
    always_ff @(posedge clk) begin
        if (!rst || new_game) begin
            state       <= WAIT;
            hold        <= '0;
            dice_button <= 1'b0;
            turn        <= 1'b0;
            score_a     <= '0;
            score_b     <= '0;
            last_throw  <= 3'd0;
            throw_valid <= 1'b0;
            winner      <= 2'b00;
            game_over   <= 1'b0;
        end else begin
            throw_valid <= 1'b0;
            case (state)
                WAIT: if (btn_cur) begin
                    state       <= ROLL;
                    dice_button <= 1'b1;
                    hold        <= '0;
                end
                ROLL: if (btn_cur) begin
                    hold <= (hold == HOLD_MAX) ? hold : hold + CW'(1);
                end else begin
                    state       <= SETTLE;
                    dice_button <= 1'b0;
                end
                SETTLE: begin
                    state <= WAIT;
                    if (roll_ok) begin
                        last_throw  <= throw;
                        throw_valid <= 1'b1;
                        if (turn) score_b <= sum[SCORE_W-1:0];
                        else score_a <= sum[SCORE_W-1:0];
                        if (sum >= TGT) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                            winner    <= turn ? 2'b10 : 2'b01;
                        end else if (!keep_turn) begin
                            turn <= ~turn;
                        end
                    end
                end
                default: dice_button <= 1'b0;
            endcase
        end
    end
endmodule
